// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: IR latch, FETCH/DECODE/EXEC/MEM/WB sequencing, retired counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt the unit and set a sticky flag.
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic        ir_we,
  output logic        pc_we,
  output logic        jump,
  output logic        branch,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        ext_op,
  output logic        mem_we,
  output logic        mem_to_reg,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU = 4'd0, I_SUBU = 4'd1, I_ORI = 4'd2, I_LUI = 4'd3,
    I_LW   = 4'd4, I_SW   = 4'd5, I_BEQ = 4'd6, I_J   = 4'd7,
    I_ILL  = 4'd8
  } instr_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  instr_e      kind_s;
  logic        ir_we_s, pc_we_s, jump_s, branch_s, reg_we_s, mem_we_s;
  logic        unused_ir_bits_s;

  function automatic instr_e decode(input logic [31:0] ir);
    instr_e k;
    case (ir[31:26])
      6'b000000: begin
        case (ir[5:0])
          6'b100001: k = I_ADDU;
          6'b100011: k = I_SUBU;
          default:   k = I_ILL;
        endcase
      end
      6'b001101: k = I_ORI;
      6'b001111: k = I_LUI;
      6'b100011: k = I_LW;
      6'b101011: k = I_SW;
      6'b000100: k = I_BEQ;
      6'b000010: k = I_J;
      default:   k = I_ILL;
    endcase
    return k;
  endfunction

  assign kind_s           = decode(ir_q);
  assign unused_ir_bits_s = ^ir_q[25:6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      retired_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    jump_s     = 1'b0;
    branch_s   = 1'b0;
    reg_we_s   = 1'b0;
    mem_we_s   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;

    // ALU controls are held steady from EXEC through MEM and WB
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (kind_s)
        I_SUBU:     alu_op = ALU_SUB;
        I_ORI:      begin alu_op = ALU_OR;  alu_src = 1'b1; end
        I_LUI:      begin alu_op = ALU_LUI; alu_src = 1'b1; end
        I_LW, I_SW: begin alu_src = 1'b1; ext_op = 1'b1; end
        I_BEQ:      alu_op = ALU_SUB;
        default:    alu_op = ALU_ADD;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_we_s = 1'b1;
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (kind_s)
          I_J: begin
            pc_we_s = 1'b1;
            jump_s  = 1'b1;
            state_d = S_FETCH;
          end
          I_ILL: begin
`ifdef ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_HALT;
`else
            pc_we_s = 1'b1;
            state_d = S_FETCH;
`endif
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (kind_s)
          I_BEQ: begin
            pc_we_s  = 1'b1;
            branch_s = 1'b1;
            state_d  = S_FETCH;
          end
          I_LW, I_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (kind_s == I_SW) begin
          mem_we_s = 1'b1;
          pc_we_s  = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we_s   = 1'b1;
        reg_dst    = (kind_s == I_ADDU) || (kind_s == I_SUBU);
        mem_to_reg = (kind_s == I_LW);
        pc_we_s    = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    retired_d = pc_we_s ? (retired_q + 32'd1) : retired_q;
  end

  // Enables are gated by rst so they drop the instant reset is asserted
  assign ir_we   = ir_we_s  & ~rst;
  assign pc_we   = pc_we_s  & ~rst;
  assign jump    = jump_s   & ~rst;
  assign branch  = branch_s & ~rst;
  assign reg_we  = reg_we_s & ~rst;
  assign mem_we  = mem_we_s & ~rst;
  assign state   = state_q;
  assign retired = retired_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; expected outputs come from a per-instruction path model.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        ir_we, pc_we, jump, branch, reg_we, reg_dst, alu_src, ext_op;
  logic        mem_we, mem_to_reg, illegal;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .ir_we(ir_we), .pc_we(pc_we), .jump(jump), .branch(branch),
    .reg_we(reg_we), .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op),
    .mem_we(mem_we), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] base_ret;
  bit exp_ill;

  // Instruction classes: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 illegal
  function automatic int kind_of(input logic [31:0] w);
    case (w[31:26])
      6'b000000: return (w[5:0] == 6'b100001) ? 0 : (w[5:0] == 6'b100011) ? 1 : 8;
      6'b001101: return 2;
      6'b001111: return 3;
      6'b100011: return 4;
      6'b101011: return 5;
      6'b000100: return 6;
      6'b000010: return 7;
      default:   return 8;
    endcase
  endfunction

  function automatic int path_len(input int k);
    int lens[9] = '{4, 4, 4, 4, 5, 4, 3, 2, 2};
    return lens[k];
  endfunction

  function automatic logic [2:0] phase_state(input int k, input int p);
    if (p <= 2) return p[2:0];
    if (p == 3 && (k == 4 || k == 5)) return 3'd3;
    return 3'd4;
  endfunction

  // {state, ir_we, pc_we, jump, branch, reg_we, reg_dst, alu_src, ext_op, mem_we, mem_to_reg, alu_op, illegal}
  function automatic logic [16:0] expect_vec(input int k, input int p, input bit ill);
    logic [2:0] st;
    logic [2:0] aop;
    logic       pcw, asrc, ext;
    st   = phase_state(k, p);
    pcw  = (p == path_len(k) - 1) && !(k == 8 && TRAP);
    aop  = 3'd0;
    asrc = 1'b0;
    ext  = 1'b0;
    if (st >= 3'd2 && st <= 3'd4) begin
      case (k)
        1: aop = 3'd1;
        2: begin aop = 3'd2; asrc = 1'b1; end
        3: begin aop = 3'd3; asrc = 1'b1; end
        4, 5: begin asrc = 1'b1; ext = 1'b1; end
        6: aop = 3'd1;
        default: aop = 3'd0;
      endcase
    end
    return {st, (p == 0), pcw, pcw && (k == 7), pcw && (k == 6),
            (st == 3'd4), (st == 3'd4) && (k <= 1), asrc, ext,
            (st == 3'd3) && (k == 5), (st == 3'd4) && (k == 4), aop, ill};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {state, ir_we, pc_we, jump, branch, reg_we, reg_dst, alu_src, ext_op,
            mem_we, mem_to_reg, alu_op, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one instruction from FETCH, comparing every cycle against the model
  task automatic run_instr(input logic [31:0] w, input bit scramble, output int pc_cycle);
    int k, n;
    k = kind_of(w);
    n = path_len(k);
    pc_cycle = 0;
    instruction = w;
    for (int p = 0; p < n; p++) begin
      if (scramble && p >= 2) instruction = 32'h8C00_0000 + p;
      @(negedge clk);
      check($sformatf("vec %08h c%0d", w, p + 1), {15'd0, dut_vec()},
            {15'd0, expect_vec(k, p, exp_ill)});
      check($sformatf("retired %08h c%0d", w, p + 1), retired, base_ret);
      if (pc_we) pc_cycle = p + 1;
      @(posedge clk);
      #1;
    end
    if (k == 8 && TRAP) exp_ill = 1'b1;
    else base_ret = base_ret + 32'd1;
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    instruction = 32'd0;
    base_ret = 32'd0;
    exp_ill = 1'b0;
    #2;
    check("reset state", {29'd0, state}, 32'd0);
    check("reset enables", {26'd0, ir_we, pc_we, jump, branch, reg_we, mem_we}, 32'd0);
    check("reset retired", retired, 32'd0);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(32'h0085_1021, 1'b0, lat);
    check("addu latency", lat, 4);
    check("addu retired", retired, 32'd1);

    run_instr(32'h8C82_0004, 1'b0, lat);
    check("lw latency", lat, 5);
    run_instr(32'hAC82_0008, 1'b0, lat);
    check("sw latency", lat, 4);
    check("lw+sw retired", retired, 32'd3);

    run_instr(32'h1085_0003, 1'b0, lat);
    check("beq latency", lat, 3);
    run_instr(32'h0800_0010, 1'b0, lat);
    check("j latency", lat, 2);

    run_instr(32'h34A5_FFFF, 1'b1, lat);
    check("ori latency", lat, 4);
    check("retired after ori", retired, 32'd6);

    run_instr(32'hFC00_0000, 1'b0, lat);
    if (TRAP) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check($sformatf("halt vec %0d", i), {15'd0, dut_vec()}, {15'd0, 17'b101_0000000000_000_1});
        check($sformatf("halt retired %0d", i), retired, 32'd6);
        @(posedge clk);
        #1;
      end
    end else begin
      check("illegal nop latency", lat, 2);
      check("retired after illegal", retired, 32'd7);
    end

    // Reset asserted while lw sits in MEM
    instruction = 32'h8C82_0004;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base_ret = 32'd0;
    exp_ill = 1'b0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      check($sformatf("lw pre-reset c%0d", p + 1), {15'd0, dut_vec()},
            {15'd0, expect_vec(4, p, 1'b0)});
      if (p < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    rst = 1'b1;
    #1;
    check("mid-reset state", {29'd0, state}, 32'd0);
    check("mid-reset enables", {26'd0, ir_we, pc_we, jump, branch, reg_we, mem_we}, 32'd0);
    check("mid-reset retired", retired, 32'd0);
    @(posedge clk);
    #1;
    check("held-reset enables", {26'd0, ir_we, pc_we, jump, branch, reg_we, mem_we}, 32'd0);
    check("held-reset retired", retired, 32'd0);
    rst = 1'b0;

    run_instr(32'h0085_1023, 1'b0, lat);
    check("subu latency", lat, 4);
    check("retired after reset", retired, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
